// File: rtl/gb_cart_pkg.sv
// Shared definitions for the cartridge backup sector engine.
//   bk_state_t   : engine state (IDLE, REQ, XFER, NEXT)
//   SECTOR_WORDS : 16-bit words per 512-byte SD sector
//   BUFF_AW      : width of the HPS word index within a sector
//   BK_ADDR_W    : width of the cart backup word address
package gb_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_NEXT
    } bk_state_t;

    localparam int unsigned SECTOR_WORDS = 256;
    localparam int unsigned BUFF_AW      = $clog2(SECTOR_WORDS);
    localparam int unsigned BK_ADDR_W    = 17;

endpackage

// File: rtl/cart_bk_sector_engine_if.sv
// Bus bundle between the sector engine, the HPS SD block device and the
// cart backup RAM port.
//   master : engine side (drives sd_lba/sd_rd/sd_wr/sd_buff_din/bk_*)
//   slave  : environment side (HPS + cart, drives sd_ack/sd_buff_*/bk_q)
interface cart_bk_sector_engine_if;
    import gb_cart_pkg::*;

    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [BUFF_AW-1:0]   sd_buff_addr;
    logic [15:0]          sd_buff_dout;
    logic                 sd_buff_wr;
    logic [15:0]          sd_buff_din;
    logic [BK_ADDR_W-1:0] bk_addr;
    logic                 bk_wr;
    logic [15:0]          bk_data;
    logic [15:0]          bk_q;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q
    );

endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (history register clears to 0)
//   d_i    : level input
//   rise_o : high for the cycle in which d_i is 1 and was 0 last cycle
module edge_detect_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cart_bk_sector_engine.sv
// Sector-level backup engine: walks the cart save image one SD sector at a
// time, requesting each sector from the HPS and bridging the HPS word buffer
// onto the cart backup RAM port.
//   clk_sys, reset_n     : clock, async active-low reset
//   bk_load, bk_save     : load/save requests (rising-edge detected)
//   img_mounted          : mount pulse, triggers a load
//   img_size             : image size in bytes, 0 = no image
//   has_save             : cart has battery-backed RAM
//   ram_mask_file        : last sector index of the image
//   busy, done, timeout  : status (done is a pulse, timeout is sticky)
//   bus                  : SD block device + cart backup port bundle
module cart_bk_sector_engine
    import gb_cart_pkg::*;
#(
    parameter int unsigned     TO_W        = 24,
    parameter logic [TO_W-1:0] ACK_TIMEOUT = TO_W'(12_000_000)
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     bk_load,
    input  logic                     bk_save,
    input  logic                     img_mounted,
    input  logic [63:0]              img_size,
    input  logic                     has_save,
    input  logic [7:0]               ram_mask_file,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    cart_bk_sector_engine_if.master  bus
);

    bk_state_t            state_q, state_d;
    logic                 dir_save_q, dir_save_d;
    logic [7:0]           lba_q, lba_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d, to_cnt_inc;
    logic                 sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic                 busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [BK_ADDR_W-1:0] bk_addr_q, bk_addr_w;
    logic [15:0]          bk_data_q, bk_data_w;
    logic                 load_rise, save_rise, load_trig, img_present;
    logic                 load_ok, save_ok, in_xfer;

    edge_detect_rise u_load_edge (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .d_i    (bk_load),
        .rise_o (load_rise)
    );

    edge_detect_rise u_save_edge (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .d_i    (bk_save),
        .rise_o (save_rise)
    );

    assign img_present = (img_size != 64'd0);
    assign load_trig   = load_rise | img_mounted;
    // A load trigger in the same cycle always suppresses a save, even when the
    // load itself is rejected for lack of an image.
    assign load_ok     = load_trig & img_present;
    assign save_ok     = save_rise & ~load_trig & img_present & has_save;
    assign to_cnt_inc  = to_cnt_q + TO_W'(1);

    always_comb begin
        state_d    = state_q;
        dir_save_d = dir_save_q;
        lba_d      = lba_q;
        to_cnt_d   = to_cnt_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_ok || save_ok) begin
                    state_d    = ST_REQ;
                    dir_save_d = save_ok;
                    lba_d      = '0;
                    to_cnt_d   = '0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.sd_ack) begin
                    state_d = ST_XFER;
                end else if (to_cnt_inc == ACK_TIMEOUT) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            ST_XFER: begin
                if (!bus.sd_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (lba_q == ram_mask_file) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = ST_REQ;
                    lba_d    = lba_q + 8'd1;
                    to_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Requests are registered from the next state so they drop on the
        // same edge that sees sd_ack and never glitch during XFER.
        sd_rd_d = (state_d == ST_REQ) && !dir_save_d;
        sd_wr_d = (state_d == ST_REQ) && dir_save_d;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dir_save_q <= 1'b0;
            lba_q      <= '0;
            to_cnt_q   <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            bk_addr_q  <= '0;
            bk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            dir_save_q <= dir_save_d;
            lba_q      <= lba_d;
            to_cnt_q   <= to_cnt_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            bk_addr_q  <= bk_addr_w;
            bk_data_q  <= bk_data_w;
        end
    end

    // Address/data pass straight through during XFER and hold afterwards.
    assign in_xfer   = (state_q == ST_XFER);
    assign bk_addr_w = in_xfer ? {1'b0, lba_q, bus.sd_buff_addr} : bk_addr_q;
    assign bk_data_w = in_xfer ? bus.sd_buff_dout : bk_data_q;

    assign bus.bk_addr     = bk_addr_w;
    assign bus.bk_data     = bk_data_w;
    assign bus.bk_wr       = in_xfer & bus.sd_buff_wr & bus.sd_ack & ~dir_save_q;
    assign bus.sd_buff_din = bus.bk_q;
    assign bus.sd_lba      = {24'd0, lba_q};
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_cart_bk_sector_engine.sv
module tb_cart_bk_sector_engine;
    import gb_cart_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = 64'd8192;
    logic        has_save = 1'b1;
    logic [7:0]  ram_mask_file = 8'h00;
    logic        busy, done, timeout;

    always #5 clk_sys = ~clk_sys;

    cart_bk_sector_engine_if bus();

    cart_bk_sector_engine #(.ACK_TIMEOUT(24'd100)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .img_mounted   (img_mounted),
        .img_size      (img_size),
        .has_save      (has_save),
        .ram_mask_file (ram_mask_file),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference image content (what the cart RAM should hold) and
    // expectation queues filled when stimulus is issued.
    logic [15:0] ref_mem [0:65535];
    logic [32:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [8:0]  exp_lba[$];
    int          exp_end[$];   // 1 = done, 2 = timeout

    int          hs_rd = 0, hs_wr = 0, bkwr_cnt = 0, req_rise_cnt = 0;
    int          rd_run = 0, last_rd_run = 0;
    logic [16:0] last_bk_addr = '0;
    bit          busy_seen = 0;
    bit          hps_mute = 0;
    logic [15:0] cur_seed = '0;
    logic        to_prev = 1'b0, req_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_empty(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT event with no expected entry", name);
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // Cart backup RAM: unwritten words read back as ~address.
    logic [15:0] cart_mem [0:65535];
    bit          cart_written [0:65535];
    always @(posedge clk_sys) begin
        if (bus.bk_wr) begin
            cart_mem[bus.bk_addr[15:0]]     <= bus.bk_data;
            cart_written[bus.bk_addr[15:0]] <= 1'b1;
        end
        bus.bk_q <= cart_written[bus.bk_addr[15:0]] ? cart_mem[bus.bk_addr[15:0]]
                                                    : ~bus.bk_addr[15:0];
    end

    // HPS model: serves one sector per request.
    task automatic serve_sector;
        bit          dir;
        logic [31:0] lba;
        logic [8:0]  e;
        logic [15:0] ew;
        dir = bus.sd_wr;
        lba = bus.sd_lba;
        if (exp_lba.size() == 0) fail_empty("sector_lba");
        else begin
            e = exp_lba.pop_front();
            check("sector_lba", {31'd0, dir, lba}, {31'd0, e[8], 24'd0, e[7:0]});
        end
        repeat ($urandom_range(0, 3)) tick();
        if (!reset_n) return;
        bus.sd_ack = 1'b1;
        if (dir) hs_wr++; else hs_rd++;
        tick();
        if (reset_n) check("req_drop", {62'd0, bus.sd_rd, bus.sd_wr}, 64'd0);
        tick();
        for (int i = 0; i < 256; i++) begin
            if (!reset_n) break;
            bus.sd_buff_addr = 8'(i);
            if (!dir) begin
                bus.sd_buff_dout = {lba[7:0], 8'(i)} ^ cur_seed;
                bus.sd_buff_wr   = 1'b1;
                tick();
                bus.sd_buff_wr   = 1'b0;
                if ($urandom_range(0, 2) == 0) tick();
            end else begin
                tick();
                if (!reset_n) break;
                if (exp_rd.size() == 0) fail_empty("save_word");
                else begin
                    ew = exp_rd.pop_front();
                    check("save_word", bus.sd_buff_din, ew);
                end
            end
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
    endtask

    initial begin
        bus.sd_ack       = 1'b0;
        bus.sd_buff_addr = '0;
        bus.sd_buff_dout = '0;
        bus.sd_buff_wr   = 1'b0;
        forever begin
            tick();
            if (reset_n && !hps_mute && (bus.sd_rd || bus.sd_wr)) serve_sector();
        end
    end

    // Monitor: compares DUT-presented events against the expectation queues.
    always @(negedge clk_sys) begin : mon
        logic [32:0] w;
        int          ev;
        if (reset_n) begin
            if (bus.bk_wr) begin
                bkwr_cnt++;
                last_bk_addr = bus.bk_addr;
                if (exp_wr.size() == 0) fail_empty("bk_write");
                else begin
                    w = exp_wr.pop_front();
                    check("bk_write", {31'd0, bus.bk_addr, bus.bk_data}, {31'd0, w});
                end
            end
            if (done) begin
                if (exp_end.size() == 0) fail_empty("end_done");
                else begin
                    ev = exp_end.pop_front();
                    check("end_done", 64'(ev), 64'd1);
                end
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
            if (timeout && !to_prev) begin
                if (exp_end.size() == 0) fail_empty("end_timeout");
                else begin
                    ev = exp_end.pop_front();
                    check("end_timeout", 64'(ev), 64'd2);
                end
            end
            if ((bus.sd_rd || bus.sd_wr) && !req_prev) req_rise_cnt++;
            if (bus.sd_rd) rd_run++;
            else if (rd_run != 0) begin
                last_rd_run = rd_run;
                rd_run = 0;
            end
            if (busy) busy_seen = 1'b1;
        end
        to_prev  = timeout;
        req_prev = bus.sd_rd | bus.sd_wr;
    end

    // Reference model: a load writes word {lba,idx}^seed to address
    // {lba,idx}; a save returns the current image words in sector order.
    task automatic push_expect(input bit save, input logic [7:0] mask, input logic [15:0] seed);
        for (int s = 0; s <= int'(mask); s++) begin
            exp_lba.push_back({save, 8'(s)});
            for (int i = 0; i < 256; i++) begin
                logic [15:0] a;
                logic [15:0] d;
                a = {8'(s), 8'(i)};
                if (save) exp_rd.push_back(ref_mem[a]);
                else begin
                    d = a ^ seed;
                    ref_mem[a] = d;
                    exp_wr.push_back({1'b0, a, d});
                end
            end
        end
        exp_end.push_back(1);
    endtask

    task automatic flush_expect;
        exp_wr.delete();
        exp_rd.delete();
        exp_lba.delete();
        exp_end.delete();
    endtask

    task automatic pulse_trigger(input int kind);
        case (kind)
            0: bk_load = 1'b1;
            1: img_mounted = 1'b1;
            2: bk_save = 1'b1;
            default: begin bk_load = 1'b1; bk_save = 1'b1; end
        endcase
        tick();
        bk_load = 1'b0;
        bk_save = 1'b0;
        img_mounted = 1'b0;
    endtask

    task automatic run_xfer(input bit save, input logic [7:0] mask, input logic [15:0] seed,
                            input int kind, input bit poke);
        int rd0, wr0, bw0, n, budget, ns;
        rd0 = hs_rd; wr0 = hs_wr; bw0 = bkwr_cnt;
        ns = int'(mask) + 1;
        budget = ns * 1000 + 100;
        ram_mask_file = mask;
        cur_seed = seed;
        push_expect(save, mask, seed);
        pulse_trigger(kind);
        check("busy_start", {63'd0, busy}, 64'd1);
        check("timeout_cleared", {63'd0, timeout}, 64'd0);
        n = 0;
        while (busy && n < budget) begin
            if (poke && n == 40) bk_save = 1'b1;
            if (poke && n == 41) bk_save = 1'b0;
            tick();
            n++;
        end
        bk_save = 1'b0;
        check("busy_end", {63'd0, busy}, 64'd0);
        tick();
        check("rd_handshakes", 64'(hs_rd - rd0), save ? 64'd0 : 64'(ns));
        check("wr_handshakes", 64'(hs_wr - wr0), save ? 64'(ns) : 64'd0);
        check("bk_wr_pulses", 64'(bkwr_cnt - bw0), save ? 64'd0 : 64'(ns * 256));
        if (!save) check("last_bk_addr", {47'd0, last_bk_addr}, {47'd0, 1'b0, mask, 8'hFF});
        check("queues_drained",
              64'(exp_wr.size() + exp_rd.size() + exp_lba.size() + exp_end.size()), 64'd0);
        check("done_low", {63'd0, done}, 64'd0);
        flush_expect();
        repeat (3) tick();
    endtask

    task automatic run_reject(input int kind, input logic [63:0] isz, input bit hs);
        int r0;
        img_size = isz;
        has_save = hs;
        r0 = req_rise_cnt;
        busy_seen = 1'b0;
        pulse_trigger(kind);
        repeat (20) tick();
        check("reject_busy", {63'd0, busy_seen}, 64'd0);
        check("reject_req", 64'(req_rise_cnt - r0), 64'd0);
        img_size = 64'd8192;
        has_save = 1'b1;
    endtask

    initial begin : stim
        int n;
        logic [15:0] seed_r;
        for (int i = 0; i < 65536; i++) ref_mem[i] = ~16'(i);

        repeat (3) tick();
        check("rst_sd_lba", {32'd0, bus.sd_lba}, 64'd0);
        check("rst_req", {62'd0, bus.sd_rd, bus.sd_wr}, 64'd0);
        check("rst_bk_wr", {63'd0, bus.bk_wr}, 64'd0);
        check("rst_bk_addr", {47'd0, bus.bk_addr}, 64'd0);
        check("rst_bk_data", {48'd0, bus.bk_data}, 64'd0);
        check("rst_status", {61'd0, busy, done, timeout}, 64'd0);
        check("rst_din", {48'd0, bus.sd_buff_din}, 64'hFFFF);
        reset_n = 1'b1;
        repeat (3) tick();

        // Save of untouched image, then a 16-sector load with a save poke.
        run_xfer(1'b1, 8'h03, 16'h0000, 2, 1'b0);
        run_xfer(1'b0, 8'h0F, 16'h0000, 0, 1'b1);

        // Rejected requests.
        run_reject(0, 64'd0, 1'b1);
        run_reject(1, 64'd0, 1'b1);
        run_reject(2, 64'd8192, 1'b0);

        // Simultaneous load and save: load wins.
        run_xfer(1'b0, 8'h01, 16'($urandom), 3, 1'b0);

        // No acknowledge: timeout after 100 cycles.
        hps_mute = 1'b1;
        exp_end.push_back(2);
        pulse_trigger(0);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        tick();
        check("timeout_rd_cycles", 64'(last_rd_run), 64'd100);
        check("timeout_flag", {63'd0, timeout}, 64'd1);
        check("timeout_busy", {63'd0, busy}, 64'd0);
        check("timeout_event", 64'(exp_end.size()), 64'd0);
        flush_expect();
        hps_mute = 1'b0;
        repeat (3) tick();
        run_xfer(1'b0, 8'h00, 16'($urandom), 0, 1'b0);

        // Reset during XFER of sector 2, then restart from sector 0.
        seed_r = 16'($urandom);
        ram_mask_file = 8'h0F;
        cur_seed = seed_r;
        push_expect(1'b0, 8'h0F, seed_r);
        pulse_trigger(0);
        n = 0;
        while (!(bus.sd_lba == 32'd2 && bus.sd_ack) && n < 3000) begin tick(); n++; end
        check("reached_sector2", {63'd0, bus.sd_lba == 32'd2 && bus.sd_ack}, 64'd1);
        repeat (20) tick();
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sd_lba", {32'd0, bus.sd_lba}, 64'd0);
        check("arst_req", {62'd0, bus.sd_rd, bus.sd_wr}, 64'd0);
        check("arst_bk_wr", {63'd0, bus.bk_wr}, 64'd0);
        check("arst_bk_addr", {47'd0, bus.bk_addr}, 64'd0);
        check("arst_bk_data", {48'd0, bus.bk_data}, 64'd0);
        check("arst_status", {61'd0, busy, done, timeout}, 64'd0);
        flush_expect();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        run_xfer(1'b0, 8'h0F, seed_r, 0, 1'b0);

        // Randomized loads and saves.
        for (int k = 0; k < 6; k++) begin
            bit sv;
            sv = 1'($urandom_range(0, 1));
            img_size = 64'($urandom_range(1, 1_000_000));
            if (sv) run_xfer(1'b1, 8'($urandom_range(0, 2)), 16'h0000, 2, 1'b0);
            else    run_xfer(1'b0, 8'($urandom_range(0, 2)), 16'($urandom),
                             int'($urandom_range(0, 1)), 1'b0);
        end
        img_size = 64'd8192;

        // Full read-back of the first 16 sectors.
        run_xfer(1'b1, 8'h0F, 16'h0000, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
